// File: rtl/bist_signature_checker.sv
// BIST run controller: counts DUT beats, requests the analyzer stop, then checks the signature.
// Optional WAIT_SIG timeout is compiled in with `define BIST_SIG_TIMEOUT_EN.
module bist_signature_checker #(
    parameter int DATA_WIDTH     = 54,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_vectors,
    input  logic [DATA_WIDTH-1:0] i_golden,
    input  logic                  i_dut_vld,
    input  logic                  i_sig_vld,
    input  logic [DATA_WIDTH-1:0] i_sig_data,
    output logic                  o_stop,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [DATA_WIDTH-1:0] o_signature,
    output logic [CNT_WIDTH-1:0]  o_beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_WAIT_SIG = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [DATA_WIDTH-1:0] golden_q, golden_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  stop_q, stop_d;
    logic                  pass_q, pass_d;
    logic [DATA_WIDTH-1:0] sig_q, sig_d;

`ifdef BIST_SIG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
`endif

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        golden_d = golden_q;
        cnt_d    = cnt_q;
        stop_d   = stop_q;
        pass_d   = pass_q;
        sig_d    = sig_q;
`ifdef BIST_SIG_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    num_d    = i_num_vectors;
                    golden_d = i_golden;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    sig_d    = '0;
`ifdef BIST_SIG_TIMEOUT_EN
                    timeout_d = 1'b0;
                    tmo_d     = '0;
`endif
                    // A zero-length run skips counting and stops the analyzer at once.
                    if (i_num_vectors == '0) begin
                        stop_d  = 1'b1;
                        state_d = ST_WAIT_SIG;
                    end else begin
                        stop_d  = 1'b0;
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (i_dut_vld) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        stop_d  = 1'b1;
                        state_d = ST_WAIT_SIG;
`ifdef BIST_SIG_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            ST_WAIT_SIG: begin
                if (i_sig_vld) begin
                    sig_d   = i_sig_data;
                    pass_d  = (i_sig_data == golden_q);
                    state_d = ST_DONE;
                end
`ifdef BIST_SIG_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    sig_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            golden_q <= '0;
            cnt_q    <= '0;
            stop_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
`ifdef BIST_SIG_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            golden_q <= golden_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            pass_q   <= pass_d;
            sig_q    <= sig_d;
`ifdef BIST_SIG_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_stop      = stop_q;
    assign o_busy      = (state_q == ST_COUNT) || (state_q == ST_WAIT_SIG);
    assign o_done      = (state_q == ST_DONE);
    assign o_pass      = pass_q;
    assign o_signature = sig_q;
    assign o_beat_cnt  = cnt_q;
`ifdef BIST_SIG_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bist_signature_checker.sv
// Self-checking bench for bist_signature_checker: directed cases plus randomized traffic
// compared every cycle against a run-level behavioural model.
module tb_bist_signature_checker;

    localparam int DW  = 54;
    localparam int CW  = 16;
    localparam int TMO = 64;
    localparam logic [DW-1:0] G = 54'h0123456789ABC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_num_vectors = '0;
    logic [DW-1:0] i_golden = '0;
    logic          i_dut_vld = 1'b0;
    logic          i_sig_vld = 1'b0;
    logic [DW-1:0] i_sig_data = '0;
    logic          o_stop, o_busy, o_done, o_pass, o_timeout;
    logic [DW-1:0] o_signature;
    logic [CW-1:0] o_beat_cnt;

    int checks = 0;
    int errors = 0;

    bist_signature_checker #(
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_num_vectors(i_num_vectors),
        .i_golden     (i_golden),
        .i_dut_vld    (i_dut_vld),
        .i_sig_vld    (i_sig_vld),
        .i_sig_data   (i_sig_data),
        .o_stop       (o_stop),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_timeout    (o_timeout),
        .o_signature  (o_signature),
        .o_beat_cnt   (o_beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Run-level model: a run is "active" from start until a result is known,
    // "stopped" once N beats are seen, and "finished" once a result is recorded.
    int          m_n = 0, m_cnt = 0, m_wait = 0;
    bit          m_active = 0, m_stopped = 0, m_finished = 0;
    bit          m_pass = 0, m_to = 0;
    logic [DW-1:0] m_gold = '0, m_sig = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_cnt = 0; m_wait = 0;
            m_active = 0; m_stopped = 0; m_finished = 0;
            m_pass = 0; m_to = 0; m_gold = '0; m_sig = '0;
        end else if (!m_active) begin
            if (i_start) begin
                m_n = int'(i_num_vectors); m_gold = i_golden;
                m_cnt = 0; m_wait = 0; m_pass = 0; m_to = 0; m_sig = '0;
                m_finished = 0; m_active = 1;
                m_stopped = (m_n == 0);
            end
        end else if (!m_stopped) begin
            if (i_dut_vld) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == m_n) begin
                    m_stopped = 1;
                    m_wait = 0;
                end
            end
        end else begin
            m_wait = m_wait + 1;
            if (i_sig_vld) begin
                m_sig = i_sig_data; m_pass = (i_sig_data == m_gold);
                m_active = 0; m_finished = 1;
            end
`ifdef BIST_SIG_TIMEOUT_EN
            else if (m_wait == TMO) begin
                m_to = 1; m_pass = 0; m_sig = '0;
                m_active = 0; m_finished = 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        check("stop",      64'(o_stop),      64'(m_stopped));
        check("busy",      64'(o_busy),      64'(m_active));
        check("done",      64'(o_done),      64'(m_finished));
        check("pass",      64'(o_pass),      64'(m_pass));
        check("timeout",   64'(o_timeout),   64'(m_to));
        check("signature", 64'(o_signature), 64'(m_sig));
        check("beat_cnt",  64'(o_beat_cnt),  64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [DW-1:0] g);
        i_start = 1'b1; i_num_vectors = CW'(n); i_golden = g;
        tick();
        i_start = 1'b0;
    endtask

    task automatic beat();
        i_dut_vld = 1'b1;
        tick();
        i_dut_vld = 1'b0;
    endtask

    task automatic send_sig(input logic [DW-1:0] d);
        i_sig_vld = 1'b1; i_sig_data = d;
        tick();
        i_sig_vld = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            tick();
            n++;
        end
        if (!o_done) check("wait_done_bound", 64'(o_done), 64'd1);
    endtask

    initial begin
        logic [63:0] r;
        tick(); tick();
        check("rst_stop", 64'(o_stop), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        rst = 1'b0;
        tick();

        // Basic pass
        start_run(4, G);
        check("start_busy", 64'(o_busy), 64'd1);
        beat(); tick(); beat(); beat();
        check("stop_before_n", 64'(o_stop), 64'd0);
        beat();
        check("stop_at_n", 64'(o_stop), 64'd1);
        check("cnt_at_n", 64'(o_beat_cnt), 64'd4);
        tick();
        send_sig(G);
        check("basic_done", 64'(o_done), 64'd1);
        check("basic_pass", 64'(o_pass), 64'd1);
        check("basic_sig",  64'(o_signature), 64'h0123456789ABC);
        check("basic_busy", 64'(o_busy), 64'd0);

        // Mismatch in bit 0, restarted from DONE
        start_run(4, G);
        check("restart_done_clr", 64'(o_done), 64'd0);
        check("restart_stop_clr", 64'(o_stop), 64'd0);
        repeat (4) beat();
        send_sig(G ^ 54'd1);
        check("mm_done", 64'(o_done), 64'd1);
        check("mm_pass", 64'(o_pass), 64'd0);
        check("mm_sig",  64'(o_signature), 64'h0123456789ABD);

        // N=0, extra beats, late signature
        start_run(0, G);
        check("n0_stop", 64'(o_stop), 64'd1);
        repeat (3) beat();
        check("n0_cnt", 64'(o_beat_cnt), 64'd0);
        send_sig(G);
        check("n0_pass", 64'(o_pass), 64'd1);
        send_sig(54'h3FFFF00000000);
        check("late_sig_held", 64'(o_signature), 64'h0123456789ABC);
        check("late_pass_held", 64'(o_pass), 64'd1);

        // Early signature during COUNT is ignored
        start_run(2, G);
        send_sig(G);
        check("early_sig_done", 64'(o_done), 64'd0);
        check("early_sig_busy", 64'(o_busy), 64'd1);
        beat(); beat();
        send_sig(G);
        check("early_then_pass", 64'(o_pass), 64'd1);

`ifdef BIST_SIG_TIMEOUT_EN
        start_run(1, G);
        beat();
        repeat (TMO - 1) tick();
        check("tmo_not_yet", 64'(o_done), 64'd0);
        tick();
        check("tmo_done", 64'(o_done), 64'd1);
        check("tmo_flag", 64'(o_timeout), 64'd1);
        check("tmo_pass", 64'(o_pass), 64'd0);
        start_run(1, G);
        beat();
        repeat (TMO - 1) tick();
        send_sig(G);
        check("tmo_race_done", 64'(o_done), 64'd1);
        check("tmo_race_flag", 64'(o_timeout), 64'd0);
        check("tmo_race_pass", 64'(o_pass), 64'd1);
`else
        start_run(1, G);
        beat();
        repeat (100) tick();
        check("no_tmo_busy", 64'(o_busy), 64'd1);
        check("no_tmo_flag", 64'(o_timeout), 64'd0);
        send_sig(G);
        check("no_tmo_pass", 64'(o_pass), 64'd1);
`endif

        // Reset mid-COUNT, then restart
        start_run(8, G);
        beat(); beat();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_cnt",  64'(o_beat_cnt), 64'd0);
        check("arst_sig",  64'(o_signature), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        start_run(3, G);
        repeat (3) beat();
        send_sig(G);
        wait_done(10);
        check("rr_pass", 64'(o_pass), 64'd1);
        check("rr_cnt",  64'(o_beat_cnt), 64'd3);
        start_run(2, G);
        check("rr_stop_clr", 64'(o_stop), 64'd0);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            r = {$urandom(), $urandom()};
            i_start       = ($urandom_range(0, 15) == 0);
            i_num_vectors = CW'($urandom_range(0, 10));
            i_golden      = r[0] ? G : ~G;
            i_dut_vld     = $urandom_range(0, 1) == 1;
            i_sig_vld     = ($urandom_range(0, 9) == 0);
            i_sig_data    = r[1] ? G : (r[2] ? ~G : r[DW-1+8:8]);
            rst           = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; i_start = 1'b0; i_dut_vld = 1'b0; i_sig_vld = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
